// File: rtl/count_7.sv
// count_7 -- 7-bit enabled up-counter with a programmable terminal value.
//
// Counts 0..TERMINAL while run is high, holding while run is low. On reaching
// TERMINAL it wraps to 0 on the next enabled edge. If COUNT_7_SATURATE_EN is
// defined it holds at TERMINAL until reset instead.
//
// Parameters:
//   TERMINAL   highest count value before wrap/saturate, legal range 1..127
//
// Ports:
//   CLK        input   rising-edge clock
//   reset      input   synchronous active-low reset (wins over run)
//   run        input   count enable, active-high
//   count_out  output  [6:0] current count, registered
//
// Configuration macro: COUNT_7_SATURATE_EN (undefined = wrap build)

module count_7 #(
   parameter logic [6:0] TERMINAL = 7'd127
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       run,
   output logic [6:0] count_out
);

   // The >= test also recovers an out-of-range power-up value on the first
   // enabled edge, so the count never exceeds TERMINAL afterwards.
   logic at_terminal;
   assign at_terminal = (count_out >= TERMINAL);

   always_ff @(posedge CLK) begin
      if (!reset) begin
         count_out <= '0;
      end else if (run) begin
         if (at_terminal) begin
`ifdef COUNT_7_SATURATE_EN
            count_out <= TERMINAL;
`else
            count_out <= '0;
`endif
         end else begin
            count_out <= count_out + 7'd1;
         end
      end
   end

endmodule

// File: tb/tb_count_7.sv
// tb_count_7 -- self-checking bench for count_7.
// Runs a default-TERMINAL instance and a TERMINAL=99 instance side by side.
// Their outputs are checked against an arithmetic reference model, together
// with directed sequences for reset, hold, wrap and saturate behaviour.
// Honours COUNT_7_SATURATE_EN in the same way as the design.

module tb_count_7;

   logic       clk;
   logic       reset;
   logic       run;
   logic [6:0] cnt_a;
   logic [6:0] cnt_b;

   int compared   = 0;
   int mismatched = 0;
   int m_a = 0;
   int m_b = 0;

   localparam int TA = 127;
   localparam int TB = 99;

`ifdef COUNT_7_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   count_7 dut_a (
      .CLK       (clk),
      .reset     (reset),
      .run       (run),
      .count_out (cnt_a)
   );

   count_7 #(.TERMINAL(7'd99)) dut_b (
      .CLK       (clk),
      .reset     (reset),
      .run       (run),
      .count_out (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: count modulo (T+1) in the wrap build, min(c+1, T) when
   // saturating. Reset clears the count, and run low leaves it unchanged.
   function automatic int next_count(input int c, input int t,
                                     input logic r, input logic u);
      if (!r) return 0;
      if (!u) return c;
      if (SAT) return (c + 1 > t) ? t : c + 1;
      return (c + 1) % (t + 1);
   endfunction

   task automatic step(input logic r, input logic u, input string tag);
      @(negedge clk);
      reset = r;
      run   = u;
      @(posedge clk);
      m_a = next_count(m_a, TA, r, u);
      m_b = next_count(m_b, TB, r, u);
      #1;
      check_val({tag, "_a"}, int'(cnt_a), m_a);
      check_val({tag, "_b"}, int'(cnt_b), m_b);
      check_val({tag, "_max_a"}, int'(cnt_a <= 7'(TA)), 1);
      check_val({tag, "_max_b"}, int'(cnt_b <= 7'(TB)), 1);
   endtask

   initial begin
      reset = 1'b0;
      run   = 1'b1;

      // Reset held two edges with run high, then 1..10.
      step(1'b0, 1'b1, "rst0");
      step(1'b0, 1'b1, "rst1");
      check_val("rst_zero", int'(cnt_a), 0);
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b1, "cnt10");
         check_val("cnt10_direct", int'(cnt_a), i);
      end

      // From 5, hold four edges, then 6, 7.
      step(1'b0, 1'b0, "rst_h");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "to5");
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, "hold");
         check_val("hold_direct", int'(cnt_a), 5);
      end
      step(1'b1, 1'b1, "resume");
      check_val("resume6", int'(cnt_a), 6);
      step(1'b1, 1'b1, "resume");
      check_val("resume7", int'(cnt_a), 7);

      // Reset at 42 with run high, then resume at 1.
      step(1'b0, 1'b1, "rst_r");
      for (int i = 0; i < 42; i++) step(1'b1, 1'b1, "to42");
      check_val("at42", int'(cnt_a), 42);
      step(1'b0, 1'b1, "mid_rst");
      check_val("mid_rst_zero", int'(cnt_a), 0);
      step(1'b1, 1'b1, "after_rst");
      check_val("after_rst_one", int'(cnt_a), 1);

      // 128 enabled edges from reset: dut_b hits 99 and wraps/saturates,
      // dut_a hits 127 and wraps/saturates.
      step(1'b0, 1'b1, "rst_w");
      for (int e = 1; e <= 128; e++) begin
         step(1'b1, 1'b1, "wrap");
         if (e == 99)  check_val("b_at_term", int'(cnt_b), 99);
         if (e == 100) check_val("b_edge100", int'(cnt_b), SAT ? 99 : 0);
         if (e == 127) check_val("a_at_term", int'(cnt_a), 127);
         if (e == 128) check_val("a_edge128", int'(cnt_a), SAT ? 127 : 0);
      end

      // Random mix of reset and run.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/count_7.md
COUNT_7 -- requirements
Module: count_7

Interface
- REQ-001 Parameter: TERMINAL, default 7'd127, highest count value before wrap; legal range 1..127.
- REQ-002 Port: CLK  input  1  rising-edge clock; all state updates on its rising edge only.
- REQ-003 Port: reset  input  1  synchronous active-low reset; sampled on rising CLK.
- REQ-004 Port: run  input  1  count enable; active-high.
- REQ-005 Port: count_out  output  7  current count, unsigned binary, driven directly from a register.
- REQ-006 One clock; reset is synchronous and active-low. No other clocks, resets or asynchronous paths exist.

Function
- REQ-007 reset=0 at a rising CLK edge: count_out SHALL become 7'd0 at that edge, regardless of run.
- REQ-008 reset=1, run=1, count_out<TERMINAL: count_out SHALL increment by exactly 1 at each rising edge.
- REQ-009 reset=1, run=0: count_out SHALL hold its value; no pending increment is remembered.
- REQ-010 Latency: a change on run affects count_out at the first rising edge where the new value is sampled; no pipeline delay.
- REQ-011 Wrap: reset=1, run=1, count_out==TERMINAL: the next edge SHALL load 7'd0 (macro-dependent, see REQ-017).
- REQ-012 count_out SHALL never exceed TERMINAL after the first reset; arithmetic is 7-bit unsigned with no carry out.
- REQ-013 reset and run asserted simultaneously: reset wins; count_out=0 and no increment that cycle.
- REQ-014 Reset mid-count: any count value SHALL be discarded and counting resumes from 0 on the first edge with reset=1, run=1.
- REQ-015 count_out is glitch-free and changes only on rising CLK.

Reset
- REQ-016 Before the first active reset edge count_out is undefined; after one rising edge with reset=0 it SHALL be 7'd0. Holding reset low for multiple cycles SHALL keep count_out at 0.

Configuration
- REQ-017 Macro COUNT_7_SATURATE_EN. Defined: at count_out==TERMINAL with run=1, count_out SHALL hold at TERMINAL until reset, instead of wrapping. Not defined: wrap to 0 per REQ-011. All other behaviour identical in both builds.

Verification
- REQ-018 reset=0 for 2 cycles with run=1, then reset=1, run=1 for 10 cycles -> count_out 0 during reset, then 1,2,...,10.
- REQ-019 From count 5, run=0 for 4 cycles, then run=1 -> count_out holds 5 for 4 edges, then 6,7.
- REQ-020 TERMINAL=99, run=1 from reset, 101 edges -> reaches 99 on edge 99; edge 100 gives 0 (macro undefined) or 99 (COUNT_7_SATURATE_EN defined); value never exceeds 99.
- REQ-021 Default TERMINAL=127, run=1 for 128 edges after reset -> 127 then 0 (macro undefined), no value >127.
- REQ-022 At count 42 drive reset=0 with run=1 for one edge -> count_out=0 at that edge; next edge with reset=1 gives 1.
